regfile_scoreboard: RTL and testbench

- Issue-side scheduler for the 32x64 register file.
- Tracks registers with an outstanding write (busy bits) and stalls issue on RAW/WAW hazards.
- Arbitrates the single register-file write port between the in-order pipeline writeback (A) and the long-latency multiply/divide writeback (B).
- Sits between decode/issue and the register file; drives the register file's RegWrite/RD/WriteData.

---
 rtl/regfile_scoreboard_if.sv | 47 ++++
 rtl/regfile_scoreboard.sv | 94 +++++++++
 tb/tb_regfile_scoreboard.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Issue, dual writeback and register-file write bundle for the register scoreboard.
// The master drives requests (decode/writeback units); the slave is the scoreboard.
interface regfile_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64
);
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rs1;
  logic [ADDR_W-1:0] iss_rs2;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_rd_wen;
  logic              iss_stall;

  logic              wba_valid;
  logic [ADDR_W-1:0] wba_rd;
  logic [DATA_W-1:0] wba_data;
  logic              wba_ready;

  logic              wbb_valid;
  logic [ADDR_W-1:0] wbb_rd;
  logic [DATA_W-1:0] wbb_data;
  logic              wbb_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic [NUM_REGS-1:0] busy_vec;
  logic [ADDR_W:0]   pending_cnt;
  logic              err_spurious;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wen,
    output wba_valid, wba_rd, wba_data,
    output wbb_valid, wbb_rd, wbb_data,
    input  iss_stall, wba_ready, wbb_ready,
    input  rf_we, rf_rd, rf_wdata, busy_vec, pending_cnt, err_spurious
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wen,
    input  wba_valid, wba_rd, wba_data,
    input  wbb_valid, wbb_rd, wbb_data,
    output iss_stall, wba_ready, wbb_ready,
    output rf_we, rf_rd, rf_wdata, busy_vec, pending_cnt, err_spurious
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: stalls issue on RAW/WAW, arbitrates the single RF write port (A default, B after starvation).
// Stall/grant are combinational; the RF write is registered (1 cycle); losers hold their request.
module regfile_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  regfile_scoreboard_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                rf_we_q;
  logic [ADDR_W-1:0]   rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                err_q, err_d;

  logic              stall, fire, a_win, b_win, grant;
  logic [ADDR_W-1:0] g_rd;
  logic [DATA_W-1:0] g_data;

  // busy_q[0] is never set, so x0 needs no special case in the hazard check.
  assign stall = bus.iss_valid & (busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2]
                                  | (bus.iss_rd_wen & busy_q[bus.iss_rd]));
  assign fire  = bus.iss_valid & ~stall;

  assign b_win  = bus.wbb_valid & (~bus.wba_valid | (starve_q >= SW'(STARVE_LIMIT)));
  assign a_win  = bus.wba_valid & ~b_win;
  assign grant  = a_win | b_win;
  assign g_rd   = b_win ? bus.wbb_rd   : bus.wba_rd;
  assign g_data = b_win ? bus.wbb_data : bus.wba_data;

  always_comb begin
    busy_d     = busy_q;
    starve_d   = '0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = err_q;
    if (bus.wbb_valid && !b_win && (starve_q < SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);
    else if (bus.wbb_valid && !b_win)
      starve_d = starve_q;
    if (grant) begin
      rf_rd_d    = g_rd;
      rf_wdata_d = g_data;
      if (g_rd != '0) begin
        if (!busy_q[g_rd]) err_d = 1'b1;
        busy_d[g_rd] = 1'b0;
      end
    end
    // Applied after the clear so a same-cycle reissue keeps the register busy.
    if (fire && bus.iss_rd_wen && (bus.iss_rd != '0))
      busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      rf_we_q    <= grant;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.iss_stall    = stall;
  assign bus.wba_ready    = a_win;
  assign bus.wbb_ready    = b_win;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_rd        = rf_rd_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.busy_vec     = busy_q;
  assign bus.pending_cnt  = cnt_q;
  assign bus.err_spurious = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: hazards, starvation arbitration, spurious writes, async reset.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(64)) bus ();

  regfile_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_rd = 0; bus.iss_rd_wen = 0;
    bus.wba_valid = 0; bus.wba_rd = 0; bus.wba_data = 0;
    bus.wbb_valid = 0; bus.wbb_rd = 0; bus.wbb_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic wen);
    bus.iss_valid = 1; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2; bus.iss_rd = rd; bus.iss_rd_wen = wen;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #2;
    chk("rst_busy", bus.busy_vec, 0);
    chk("rst_cnt", bus.pending_cnt, 0);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_rd", bus.rf_rd, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_err", bus.err_spurious, 0);
    chk("rst_stall", bus.iss_stall, 0);
    #10 reset = 1;
    tick();

    // RAW on x5 until A writes it back
    issue(0, 0, 5, 1);
    #1 chk("i5_stall", bus.iss_stall, 0);
    tick();
    idle();
    chk("i5_busy", bus.busy_vec, 64'h20);
    chk("i5_cnt", bus.pending_cnt, 1);
    issue(5, 0, 0, 0);
    #1 chk("raw_stall0", bus.iss_stall, 1);
    tick();
    chk("raw_stall1", bus.iss_stall, 1);
    bus.wba_valid = 1; bus.wba_rd = 5; bus.wba_data = 64'hAAAA_5555;
    #1 chk("a5_ready", bus.wba_ready, 1);
    chk("a5_nobypass", bus.iss_stall, 1);
    tick();
    bus.wba_valid = 0;
    chk("a5_we", bus.rf_we, 1);
    chk("a5_rd", bus.rf_rd, 5);
    chk("a5_wdata", bus.rf_wdata, 64'hAAAA_5555);
    chk("a5_busy", bus.busy_vec, 0);
    chk("a5_cnt", bus.pending_cnt, 0);
    #1 chk("a5_unstall", bus.iss_stall, 0);
    tick();
    idle();
    chk("nogrant_we", bus.rf_we, 0);
    chk("nogrant_rd", bus.rf_rd, 5);

    // x0 is never busy; writing it is not spurious
    issue(0, 0, 0, 1);
    #1 chk("x0_stall", bus.iss_stall, 0);
    tick();
    idle();
    chk("x0_busy", bus.busy_vec, 0);
    bus.wba_valid = 1; bus.wba_rd = 0; bus.wba_data = 64'h77;
    tick();
    idle();
    chk("x0_we", bus.rf_we, 1);
    chk("x0_rd", bus.rf_rd, 0);
    chk("x0_err", bus.err_spurious, 0);

    // B alone wins immediately
    bus.wbb_valid = 1; bus.wbb_rd = 0; bus.wbb_data = 64'h3333;
    #1 chk("bsolo_ready", bus.wbb_ready, 1);
    tick();
    idle();
    chk("bsolo_wdata", bus.rf_wdata, 64'h3333);

    // Both requesting: A wins 4 cycles, B forced on the 5th, then A again
    for (int c = 0; c < 6; c++) begin
      bus.wba_valid = 1; bus.wba_rd = 0; bus.wba_data = 64'h1111;
      bus.wbb_valid = 1; bus.wbb_rd = 0; bus.wbb_data = 64'h2222;
      #1;
      chk($sformatf("starve_a%0d", c), bus.wba_ready, (c == 4) ? 0 : 1);
      chk($sformatf("starve_b%0d", c), bus.wbb_ready, (c == 4) ? 1 : 0);
      tick();
      chk($sformatf("starve_w%0d", c), bus.rf_wdata, (c == 4) ? 64'h2222 : 64'h1111);
    end
    idle();

    // Spurious write to idle x9, sticky until reset
    bus.wba_valid = 1; bus.wba_rd = 9; bus.wba_data = 64'h99;
    tick();
    idle();
    chk("sp_we", bus.rf_we, 1);
    chk("sp_rd", bus.rf_rd, 9);
    chk("sp_err", bus.err_spurious, 1);
    tick();
    chk("sp_hold", bus.err_spurious, 1);
    reset = 0;
    #1 chk("sp_rst", bus.err_spurious, 0);
    reset = 1;
    tick();

    // Grant and issue of x7 in the same cycle: set wins
    bus.wba_valid = 1; bus.wba_rd = 7; bus.wba_data = 64'h7;
    issue(0, 0, 7, 1);
    #1 chk("sc_stall", bus.iss_stall, 0);
    tick();
    idle();
    chk("sc_busy", bus.busy_vec, 64'h80);
    chk("sc_cnt", bus.pending_cnt, 1);
    reset = 0;
    #1 reset = 1;
    tick();

    // Three busy with a write in flight, then async reset mid-cycle
    issue(0, 0, 1, 1); tick();
    issue(0, 0, 2, 1); tick();
    issue(0, 0, 3, 1); tick();
    issue(0, 0, 4, 1);
    bus.wba_valid = 1; bus.wba_rd = 1; bus.wba_data = 64'h1;
    tick();
    idle();
    chk("mr_busy", bus.busy_vec, 64'h1C);
    chk("mr_cnt", bus.pending_cnt, 3);
    chk("mr_we", bus.rf_we, 1);
    #1 reset = 0;
    #1;
    chk("mr_busy0", bus.busy_vec, 0);
    chk("mr_cnt0", bus.pending_cnt, 0);
    chk("mr_we0", bus.rf_we, 0);
    reset = 1;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
